bju_bp: RTL and testbench

- Parametrised successor to the combinational branch/jump unit.
- Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR in EX, as before, and adds a dynamic predictor for IF: a BHT of 2-bit saturating counters plus a direct-mapped BTB.
- Detects mispredictions and issues a registered one-cycle flush/redirect to the front end.
- Optionally keeps performance counters.

---
 rtl/bju_pkg.sv | 52 +++++
 rtl/bju_bht.sv | 50 +++++
 rtl/bju_bp.sv | 159 +++++++++++++++
 tb/tb_bju_bp.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bju_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bju_pkg
// Description : Shared mnemonic codes, predictor counter/BTB types and the
//               saturating counter helper for the branch/jump unit.
// Revision    : 1.0 - initial release
// ============================================================================
package bju_pkg;

    localparam logic [5:0] c_mn_beq  = 6'd24;
    localparam logic [5:0] c_mn_bne  = 6'd25;
    localparam logic [5:0] c_mn_blt  = 6'd26;
    localparam logic [5:0] c_mn_bge  = 6'd27;
    localparam logic [5:0] c_mn_bltu = 6'd28;
    localparam logic [5:0] c_mn_bgeu = 6'd29;
    localparam logic [5:0] c_mn_jal  = 6'd30;
    localparam logic [5:0] c_mn_jalr = 6'd31;

    // BTB fields are sized for the widest supported configuration; unused
    // upper bits are written as zero and trimmed by synthesis.
    localparam int c_btb_xlen_max = 64;
    localparam int c_btb_tag_max  = 32;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    typedef struct packed {
        logic                      valid;
        logic                      is_jump;
        logic [c_btb_tag_max-1:0]  tag;
        logic [c_btb_xlen_max-1:0] target;
    } btb_entry_t;

    localparam bht_cnt_t c_bht_reset = WNT;

    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t w_nxt;
        w_nxt = cnt;
        if (taken && (cnt != ST)) begin
            w_nxt = bht_cnt_t'(cnt + 2'd1);
        end else if (!taken && (cnt != SNT)) begin
            w_nxt = bht_cnt_t'(cnt - 2'd1);
        end
        return w_nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bju_bht.sv
`default_nettype none
// ============================================================================
// Module      : bju_bht
// Description : 2-bit counter history table plus direct-mapped BTB storage,
//               one combinational read port and one write/update port.
// Revision    : 1.0 - initial release
// ============================================================================
module bju_bht
    import bju_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_cnt_t         o_rd_cnt,
    output btb_entry_t       o_rd_entry,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_cnt_we,
    input  logic             i_cnt_taken,
    input  logic             i_btb_we,
    input  btb_entry_t       i_btb_wdata
);

    bht_cnt_t   r_cnt [DEPTH];
    btb_entry_t r_btb [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= c_bht_reset;
                r_btb[i] <= '0;
            end
        end else begin
            if (i_cnt_we) begin
                r_cnt[i_wr_idx] <= bht_next(r_cnt[i_wr_idx], i_cnt_taken);
            end
            if (i_btb_we) begin
                r_btb[i_wr_idx] <= i_btb_wdata;
            end
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the old entry.
    assign o_rd_cnt   = r_cnt[i_rd_idx];
    assign o_rd_entry = r_btb[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/bju_bp.sv
`default_nettype none
// ============================================================================
// Module      : bju_bp
// Description : Branch/jump resolve unit with BHT+BTB fetch predictor and a
//               registered mispredict flush/redirect. Performance counters
//               are built only when BJU_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bju_bp
    import bju_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int TAG_W     = 8,
    parameter int CNT_W     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [5:0]      i_mnemonic,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic [XLEN-1:0] i_fw_rs1_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_flush,
    output logic [XLEN-1:0] o_redirect_addr,
    output logic            o_misaligned
`ifdef BJU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] o_mispredict_cnt,
    output logic [CNT_W-1:0] o_branch_cnt
`endif
);

    localparam int              IDX_W      = $clog2(BHT_DEPTH);
    localparam logic [XLEN-1:0] c_four     = XLEN'(4);
    localparam logic [XLEN-1:0] c_bit0_clr = ~XLEN'(1);

    logic [IDX_W-1:0] w_if_idx, w_ex_idx;
    logic [TAG_W-1:0] w_if_tag, w_ex_tag;
    bht_cnt_t         w_rd_cnt;
    btb_entry_t       w_rd_entry, w_btb_wdata;
    logic             w_hit, w_is_br, w_is_jmp, w_cond, w_taken;
    logic             w_act, w_mispredict, w_cnt_we, w_btb_we, w_unused;
    logic [XLEN-1:0]  w_target, w_next;
    logic             r_flush, r_misaligned;
    logic [XLEN-1:0]  r_redirect;

    // Fetch-side lookup
    assign w_if_idx      = i_if_pc[IDX_W+1:2];
    assign w_if_tag      = i_if_pc[IDX_W+2 +: TAG_W];
    assign w_hit         = w_rd_entry.valid && (w_rd_entry.tag[TAG_W-1:0] == w_if_tag);
    assign o_pred_taken  = w_hit && (w_rd_entry.is_jump || (w_rd_cnt == WT) || (w_rd_cnt == ST));
    assign o_pred_target = o_pred_taken ? w_rd_entry.target[XLEN-1:0] : i_if_pc + c_four;
    assign w_unused      = ^{w_rd_entry.tag, w_rd_entry.target};

    always_comb begin
        w_is_br = 1'b0;
        w_cond  = 1'b0;
        case (i_mnemonic)
            c_mn_beq:  begin w_is_br = 1'b1; w_cond = (i_src1 == i_src2); end
            c_mn_bne:  begin w_is_br = 1'b1; w_cond = (i_src1 != i_src2); end
            c_mn_blt:  begin w_is_br = 1'b1; w_cond = ($signed(i_src1) <  $signed(i_src2)); end
            c_mn_bge:  begin w_is_br = 1'b1; w_cond = ($signed(i_src1) >= $signed(i_src2)); end
            c_mn_bltu: begin w_is_br = 1'b1; w_cond = (i_src1 <  i_src2); end
            c_mn_bgeu: begin w_is_br = 1'b1; w_cond = (i_src1 >= i_src2); end
            default:   ;
        endcase
    end

    assign w_is_jmp = (i_mnemonic == c_mn_jal) || (i_mnemonic == c_mn_jalr);
    assign w_taken  = w_is_jmp || w_cond;
    assign w_target = (i_mnemonic == c_mn_jalr) ? ((i_fw_rs1_data + i_imm) & c_bit0_clr)
                                                : (i_pc + i_imm);
    assign w_next   = w_taken ? w_target : (i_pc + c_four);

    // EX is wrong-path while a flush is on its way out, so it is ignored then.
    assign w_act        = i_ex_valid && !r_flush && (w_is_br || w_is_jmp);
    assign w_mispredict = w_act && ((w_taken != i_ex_pred_taken) ||
                                    (w_taken && (w_target != i_ex_pred_target)));

    assign w_ex_idx = i_pc[IDX_W+1:2];
    assign w_ex_tag = i_pc[IDX_W+2 +: TAG_W];
    assign w_cnt_we = w_act && w_is_br;
    assign w_btb_we = w_act && w_taken && !w_target[1];

    always_comb begin
        w_btb_wdata                    = '0;
        w_btb_wdata.valid              = 1'b1;
        w_btb_wdata.is_jump            = w_is_jmp;
        w_btb_wdata.tag[TAG_W-1:0]     = w_ex_tag;
        w_btb_wdata.target[XLEN-1:0]   = w_target;
    end

    bju_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rd_idx    (w_if_idx),
        .o_rd_cnt    (w_rd_cnt),
        .o_rd_entry  (w_rd_entry),
        .i_wr_idx    (w_ex_idx),
        .i_cnt_we    (w_cnt_we),
        .i_cnt_taken (w_taken),
        .i_btb_we    (w_btb_we),
        .i_btb_wdata (w_btb_wdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush      <= 1'b0;
            r_misaligned <= 1'b0;
            r_redirect   <= '0;
        end else begin
            r_flush      <= w_mispredict;
            r_misaligned <= w_mispredict && w_taken && w_target[1];
            if (w_mispredict) begin
                r_redirect <= w_next;
            end
        end
    end

    assign o_flush         = r_flush;
    assign o_misaligned    = r_misaligned;
    assign o_redirect_addr = r_redirect;

`ifdef BJU_PERF_CNT_EN
    logic [CNT_W-1:0] r_branch_cnt, r_mispredict_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_act && (~&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (~&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(1);
            end
        end
    end

    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;
`else
    localparam int c_unused_cnt_w = CNT_W;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bju_bp.sv
`default_nettype none
// ============================================================================
// Module      : tb_bju_bp
// Description : Directed bench for bju_bp with a per-cycle reference model of
//               the predictor/flush behaviour and hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bju_bp;
    import bju_pkg::*;

    localparam int XLEN = 32, BHT_DEPTH = 64, TAG_W = 8, CNT_W = 32, IDX_W = 6;

    logic            clk = 1'b0, rst = 1'b0;
    logic [XLEN-1:0] if_pc, src1, src2, rs1, imm, pc, ex_pred_target;
    logic [XLEN-1:0] pred_target, redirect;
    logic [5:0]      mnemonic;
    logic            ex_valid, ex_pred_taken, pred_taken, flush, misaligned;
`ifdef BJU_PERF_CNT_EN
    logic [CNT_W-1:0] mis_cnt, br_cnt;
`endif

    int n_checks = 0, n_fail = 0;

    bju_bp #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_if_pc(if_pc),
        .o_pred_taken(pred_taken), .o_pred_target(pred_target),
        .i_ex_valid(ex_valid), .i_mnemonic(mnemonic), .i_src1(src1), .i_src2(src2),
        .i_fw_rs1_data(rs1), .i_imm(imm), .i_pc(pc),
        .i_ex_pred_taken(ex_pred_taken), .i_ex_pred_target(ex_pred_target),
        .o_flush(flush), .o_redirect_addr(redirect), .o_misaligned(misaligned)
`ifdef BJU_PERF_CNT_EN
        , .o_mispredict_cnt(mis_cnt), .o_branch_cnt(br_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: counters as integers 0..3, BTB as plain arrays.
    int              m_cnt [BHT_DEPTH];
    bit              m_v   [BHT_DEPTH];
    bit              m_j   [BHT_DEPTH];
    logic [TAG_W-1:0] m_tag [BHT_DEPTH];
    logic [XLEN-1:0] m_tgt [BHT_DEPTH];
    bit              m_flush, m_mis;
    logic [XLEN-1:0] m_redir;
    longint          m_bcnt, m_mcnt;

    task automatic model_reset();
        for (int i = 0; i < BHT_DEPTH; i++) begin
            m_cnt[i] = 1;
            m_v[i]   = 0;
        end
        m_flush = 0; m_mis = 0; m_redir = '0; m_bcnt = 0; m_mcnt = 0;
    endtask

    task automatic model_step();
        bit br, jmp, tk, act, mp;
        logic [XLEN-1:0] tgt, nxt;
        int ix;
        br  = mnemonic inside {c_mn_beq, c_mn_bne, c_mn_blt, c_mn_bge, c_mn_bltu, c_mn_bgeu};
        jmp = mnemonic inside {c_mn_jal, c_mn_jalr};
        case (mnemonic)
            c_mn_beq:  tk = (src1 == src2);
            c_mn_bne:  tk = (src1 != src2);
            c_mn_blt:  tk = ($signed(src1) < $signed(src2));
            c_mn_bge:  tk = !($signed(src1) < $signed(src2));
            c_mn_bltu: tk = (src1 < src2);
            c_mn_bgeu: tk = !(src1 < src2);
            default:   tk = jmp;
        endcase
        if (mnemonic == c_mn_jalr) begin
            tgt    = rs1 + imm;
            tgt[0] = 1'b0;
        end else begin
            tgt = pc + imm;
        end
        nxt = tk ? tgt : pc + 32'd4;
        act = ex_valid && !m_flush && (br || jmp);
        mp  = act && ((tk != ex_pred_taken) || (tk && tgt != ex_pred_target));
        if (act) begin
            ix = int'(pc[IDX_W+1:2]);
            if (br) m_cnt[ix] = tk ? ((m_cnt[ix] < 3) ? m_cnt[ix] + 1 : 3)
                                   : ((m_cnt[ix] > 0) ? m_cnt[ix] - 1 : 0);
            if (tk && !tgt[1]) begin
                m_v[ix] = 1; m_j[ix] = jmp; m_tag[ix] = pc[IDX_W+2 +: TAG_W]; m_tgt[ix] = tgt;
            end
            m_bcnt++;
        end
        if (mp) begin
            m_redir = nxt;
            m_mcnt++;
        end
        m_mis   = mp && tk && tgt[1];
        m_flush = mp;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            int  ix;
            bit  e_tk;
            ix   = int'(if_pc[IDX_W+1:2]);
            e_tk = m_v[ix] && (m_tag[ix] == if_pc[IDX_W+2 +: TAG_W]) && (m_j[ix] || m_cnt[ix] >= 2);
            check("model pred_taken", pred_taken, e_tk);
            check("model pred_target", pred_target, e_tk ? m_tgt[ix] : if_pc + 32'd4);
            check("model flush", flush, m_flush);
            check("model redirect", redirect, m_redir);
            check("model misaligned", misaligned, m_mis);
`ifdef BJU_PERF_CNT_EN
            check("model branch_cnt", br_cnt, 64'(m_bcnt));
            check("model mispredict_cnt", mis_cnt, 64'(m_mcnt));
`endif
        end
    end

    task automatic do_op(input logic [5:0] mn, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] r1, input logic [31:0] im, input logic [31:0] p,
                         input logic pt, input logic [31:0] ptg);
        @(posedge clk); #2;
        mnemonic = mn; src1 = s1; src2 = s2; rs1 = r1; imm = im; pc = p;
        ex_pred_taken = pt; ex_pred_target = ptg; ex_valid = 1'b1;
        @(posedge clk); #2;
        ex_valid = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    initial begin
        if_pc = 32'h100; src1 = '0; src2 = '0; rs1 = '0; imm = '0; pc = '0;
        mnemonic = 6'd0; ex_valid = 1'b0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        settle();
        check("reset flush", flush, 0);
        check("reset redirect", redirect, 0);
        check("reset misaligned", misaligned, 0);
        check("reset pred_taken", pred_taken, 0);
        check("reset pred_target", pred_target, 32'h104);

        // BEQ taken, predicted not-taken
        do_op(c_mn_beq, 5, 5, 0, 32'h20, 32'h100, 1'b0, 32'h104);
        settle();
        check("beq1 flush", flush, 1);
        check("beq1 redirect", redirect, 32'h120);
        check("beq1 pred_taken", pred_taken, 1);
        check("beq1 pred_target", pred_target, 32'h120);

        for (int k = 0; k < 3; k++) begin
            do_op(c_mn_beq, 5, 5, 0, 32'h20, 32'h100, 1'b1, 32'h120);
            settle();
            check("beq taken flush", flush, 0);
        end

        do_op(c_mn_beq, 5, 6, 0, 32'h20, 32'h100, 1'b1, 32'h120);
        settle();
        check("beq nt flush", flush, 1);
        check("beq nt redirect", redirect, 32'h104);
        check("beq nt pred_taken", pred_taken, 1);
        check("beq nt pred_target", pred_target, 32'h120);

        // JALR at 0x200 shares index 0 with 0x100 but carries a different tag
        if_pc = 32'h200;
        do_op(c_mn_jalr, 0, 0, 32'h2001, 32'h4, 32'h200, 1'b1, 32'h2004);
        settle();
        check("jalr flush", flush, 0);
        check("jalr pred_taken", pred_taken, 1);
        check("jalr pred_target", pred_target, 32'h2004);
        if_pc = 32'h100; #1;
        check("replaced pred_taken", pred_taken, 0);
        check("replaced pred_target", pred_target, 32'h104);

        do_op(c_mn_jalr, 0, 0, 32'h2002, 32'h0, 32'h200, 1'b1, 32'h2004);
        settle();
        check("jalr mis flush", flush, 1);
        check("jalr mis misaligned", misaligned, 1);
        check("jalr mis redirect", redirect, 32'h2002);
        if_pc = 32'h200; #1;
        check("jalr mis btb kept", pred_target, 32'h2004);

        // Back-to-back mispredicts: the second sits in EX during the flush
        @(posedge clk); #2;
        mnemonic = c_mn_bne; src1 = 1; src2 = 2; imm = 32'h40; pc = 32'h304;
        ex_pred_taken = 1'b0; ex_pred_target = 32'h308; ex_valid = 1'b1;
        @(posedge clk); #2;
        pc = 32'h380; imm = 32'h10; ex_pred_target = 32'h384;
        settle();
        check("b2b first flush", flush, 1);
        check("b2b first redirect", redirect, 32'h344);
        @(posedge clk); #2;
        ex_valid = 1'b0;
        settle();
        check("b2b second flush", flush, 0);
        check("b2b redirect held", redirect, 32'h344);
        if_pc = 32'h380; #1;
        check("b2b no update", pred_taken, 0);
        if_pc = 32'h304; #1;
        check("b2b first update", pred_target, 32'h344);

        // Fresh run of 10 control ops, 3 mispredicted
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        do_op(c_mn_blt,  32'hFFFF_FFFF, 1, 0, 32'h10, 32'h400, 1'b1, 32'h410);
        do_op(c_mn_bltu, 32'hFFFF_FFFF, 1, 0, 32'h10, 32'h404, 1'b0, 32'h408);
        do_op(c_mn_bge,  1, 32'hFFFF_FFFF, 0, 32'h8, 32'h408, 1'b0, 32'h40C);
        settle();
        check("bge signed flush", flush, 1);
        check("bge signed redirect", redirect, 32'h410);
        do_op(c_mn_bgeu, 1, 32'hFFFF_FFFF, 0, 32'h8, 32'h40C, 1'b0, 32'h410);
        settle();
        check("bgeu unsigned flush", flush, 0);
        do_op(c_mn_bge,  5, 5, 0, 32'h20, 32'h410, 1'b1, 32'h430);
        do_op(c_mn_bltu, 3, 3, 0, 32'h20, 32'h414, 1'b0, 32'h418);
        do_op(c_mn_jal,  0, 0, 0, 32'h100, 32'h418, 1'b1, 32'h518);
        do_op(c_mn_jal,  0, 0, 0, 32'hFFFF_FFFC, 32'h41C, 1'b1, 32'h420);
        settle();
        check("jal target flush", flush, 1);
        check("jal target redirect", redirect, 32'h418);
        do_op(c_mn_bne,  7, 7, 0, 32'h20, 32'h420, 1'b1, 32'h440);
        settle();
        check("bne nt redirect", redirect, 32'h424);
        do_op(c_mn_beq,  0, 0, 0, 32'h8, 32'h424, 1'b1, 32'h42C);
        do_op(6'd1,      1, 2, 0, 32'h8, 32'h428, 1'b1, 32'h500);
        settle();
        check("non-ctrl flush", flush, 0);
`ifdef BJU_PERF_CNT_EN
        check("perf branch_cnt", br_cnt, 10);
        check("perf mispredict_cnt", mis_cnt, 3);
`endif
        if_pc = 32'h400; #1;
        check("blt pred_target", pred_target, 32'h410);

        // Reset while a flush is being presented
        do_op(c_mn_beq, 1, 1, 0, 32'h10, 32'h508, 1'b0, 32'h50C);
        #1;
        check("pending flush", flush, 1);
        rst = 1'b1;
        #1;
        check("async rst flush", flush, 0);
        check("async rst redirect", redirect, 0);
        check("async rst pred_taken", pred_taken, 0);
        check("async rst pred_target", pred_target, 32'h404);
`ifdef BJU_PERF_CNT_EN
        check("async rst branch_cnt", br_cnt, 0);
        check("async rst mispredict_cnt", mis_cnt, 0);
`endif
        @(posedge clk); #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
